apb_config_regbank: RTL

Parametrised APB3 completer holding NUM_REGS configuration registers. It is the generalised successor to the fixed two-register APB config block.
- Adds: configurable register count, per-register read-only status slots, per-register reset values, and programmable wait states.
- Adds: PSLVERR on bad accesses and a one-cycle write-notification pulse per register.
- Sits between the APB interconnect and the datapath blocks that consume configuration.

---
 rtl/apb_cfg_pkg.sv | 19 +
 rtl/apb_slave_fsm.sv | 55 +++++
 rtl/apb_config_regbank.sv | 139 +++++++++++++
 3 files changed

// File: rtl/apb_cfg_pkg.sv
// Shared types and helpers for APB configuration completers.
package apb_cfg_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    localparam int          ADDR_LSB          = 2;
    localparam int          MAX_REGS          = 64;
    localparam int          MAX_BITS          = MAX_REGS * 32;
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    function automatic logic [31:0] get_slot(input logic [MAX_BITS-1:0] vec,
                                             input logic [5:0]          idx);
        return vec[{idx, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/apb_slave_fsm.sv
// APB completer handshake engine: IDLE/ACCESS state, wait-state counter,
// PREADY and the commit/abort strobes for the register logic.
module apb_slave_fsm
    import apb_cfg_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       psel,
    input  logic       penable,
    output apb_state_t state,
    output logic       pready,
    output logic       setup,
    output logic       commit,
    output logic       abort
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    apb_state_t next_state;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (setup)
                cnt <= '0;
            else if (state == ACCESS && cnt < WS)
                cnt <= cnt + 4'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (psel && !penable) next_state = ACCESS;
            ACCESS:  if (!psel || pready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake: a transfer completes on the edge where pready is high with
    // psel still asserted; psel dropping earlier abandons it with no side effect.
    always_comb begin
        pready = (state == ACCESS) && penable && (cnt == WS);
        setup  = (state == IDLE) && psel && !penable;
        commit = pready && psel;
        abort  = (state == ACCESS) && !psel;
    end

endmodule

// File: rtl/apb_config_regbank.sv
// Parametrised APB3 configuration register bank with read-only status slots,
// wait states, PSLVERR on bad accesses and per-slot write pulses.
module apb_config_regbank
    import apb_cfg_pkg::*;
#(
    parameter int                     NUM_REGS    = 4,
    parameter int                     WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
    parameter logic [NUM_REGS*32-1:0] RST_VAL     = '0,
    parameter logic [31:0]            ERR_RDATA   = DEFAULT_ERR_RDATA
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic [31:0]              PADDR,
    input  logic                     PWRITE,
    input  logic [31:0]              PWDATA,
    output logic [31:0]              PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    input  logic [NUM_REGS*32-1:0]   status_in,
    output logic [NUM_REGS*32-1:0]   cfg_out,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    apb_state_t state;
    logic       setup, commit, abort;

    logic [5:0]  idx_q;
    logic        wr_q, err_q;
    logic [31:0] wdata_q;

    logic [29:0]         paddr_idx;
    logic [5:0]          paddr_slot;
    logic                oob, misaligned, err_now;
    logic                wr_commit;
    logic [NUM_REGS-1:0] hit;

    logic [MAX_BITS-1:0] cfg_pad, status_pad;
    logic [MAX_REGS-1:0] ro_pad;

    apb_slave_fsm #(
        .WAIT_STATES(WAIT_STATES)
    ) u_fsm (
        .clk    (PCLK),
        .rst    (PRESET),
        .psel   (PSEL),
        .penable(PENABLE),
        .state  (state),
        .pready (PREADY),
        .setup  (setup),
        .commit (commit),
        .abort  (abort)
    );

    // Pad to the package-wide maximum so slot lookups never index out of range.
    always_comb begin
        cfg_pad                       = '0;
        cfg_pad[NUM_REGS*32-1:0]      = cfg_out;
        status_pad                    = '0;
        status_pad[NUM_REGS*32-1:0]   = status_in;
        ro_pad                        = '0;
        ro_pad[NUM_REGS-1:0]          = RO_MASK;
    end

    function automatic logic [31:0] rd_sel(input logic                err,
                                           input logic [5:0]          slot,
                                           input logic [MAX_BITS-1:0] cfgv,
                                           input logic [MAX_BITS-1:0] stv,
                                           input logic [MAX_REGS-1:0] ro);
        if (err)
            return ERR_RDATA;
        else if (ro[slot])
            return get_slot(stv, slot);
        return get_slot(cfgv, slot);
    endfunction

    always_comb begin
        paddr_idx  = PADDR[31:ADDR_LSB];
        paddr_slot = PADDR[ADDR_LSB +: 6];
        oob        = paddr_idx >= 30'(NUM_REGS);
        misaligned = PADDR[1:0] != 2'b00;
        err_now    = oob || misaligned || (PWRITE && !oob && ro_pad[paddr_slot]);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            PRDATA  <= '0;
        end else if (setup) begin
            idx_q   <= paddr_slot;
            wr_q    <= PWRITE;
            err_q   <= err_now;
            wdata_q <= PWDATA;
            PRDATA  <= rd_sel(err_now, paddr_slot, cfg_pad, status_pad, ro_pad);
        end else if (state == ACCESS) begin
            PRDATA <= rd_sel(err_q, idx_q, cfg_pad, status_pad, ro_pad);
            if (abort)
                wr_q <= 1'b0;
        end
    end

    assign PSLVERR   = PREADY && err_q;
    assign wr_commit = commit && wr_q && !err_q;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REGS; i++)
            hit[i] = wr_commit && (idx_q == 6'(i));
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            wr_pulse <= '0;
        else
            wr_pulse <= hit;
    end

    // RO slots hold no storage; their cfg_out slice is tied to zero.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
        if (RO_MASK[i]) begin : g_ro
            assign cfg_out[32*i +: 32] = '0;
        end else begin : g_rw
            logic [31:0] r;
            always_ff @(posedge PCLK or posedge PRESET) begin
                if (PRESET)
                    r <= RST_VAL[32*i +: 32];
                else if (hit[i])
                    r <= wdata_q;
            end
            assign cfg_out[32*i +: 32] = r;
        end
    end

endmodule
